// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
//
// Two-requester round-robin arbiter and sequencer in front of DataMemory
// (64-bit words, byte addressed, big-endian, 10-bit address). Requester 0 is
// the core load/store path, requester 1 the DMA/debug port. One command is
// registered, DataMemory is driven for exactly one cycle, and read data is
// returned with a one-cycle valid pulse. Misaligned addresses (addr[2:0] != 0)
// never reach the memory and are answered with a one-cycle error pulse.
//
// Handshake: a requester raises rN_req with rN_we/rN_addr/rN_wdata and holds
// all of them stable until the cycle in which rN_gnt is high. rN_gnt is a
// one-cycle accept pulse coinciding with the memory strobe. After that cycle
// the requester may drop req or present a new command. Responses follow one
// cycle after gnt: rN_rvalid for an aligned read, rN_err for a misaligned
// access, nothing for an aligned write (gnt is its completion).
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   rN_req/we/addr/wdata requester N command inputs (N = 0, 1)
//   rN_gnt              one-cycle accept pulse (during the memory access)
//   rN_rvalid/rN_rdata  read response; rdata held until the next read
//   rN_err              one-cycle misaligned-access pulse
//   mem_*               DataMemory address / write data / strobes / read data
//   busy                high while in ACCESS or RESP
//   dbg_state           current FSM state (0 IDLE, 1 ACCESS, 2 RESP)
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  // requester 0
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_err,
  // requester 1
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_err,
  // DataMemory
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  input  logic [DATA_W-1:0] mem_read_data,
  // status
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Latched command
  logic              cmd_id;
  logic              cmd_we;
  logic              cmd_err;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // Id of the most recently granted requester; resets to 1 so r0 wins the
  // first tie.
  logic last_grant;

  // Arbitration signals
  logic any_req;
  logic win_id;
  logic take;
  logic win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // ------------------------------------------------------------------------
  // Arbitration: only evaluated in IDLE and RESP; req is ignored in ACCESS.
  // ------------------------------------------------------------------------
  always_comb begin
    any_req = r0_req | r1_req;
    // Tie goes to the requester that was not granted last.
    if (r0_req && r1_req) win_id = ~last_grant;
    else                  win_id = r1_req;
    take = any_req && ((state == IDLE) || (state == RESP));
    if (win_id) begin
      win_we    = r1_we;
      win_addr  = r1_addr;
      win_wdata = r1_wdata;
    end else begin
      win_we    = r0_we;
      win_addr  = r0_addr;
      win_wdata = r0_wdata;
    end
  end

  // ------------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // ------------------------------------------------------------------------
  // FSM: next-state logic
  // ------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = any_req ? ACCESS : IDLE;
      ACCESS:  state_next = RESP;
      RESP:    state_next = any_req ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Command latch and round-robin pointer
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_id     <= 1'b0;
      cmd_we     <= 1'b0;
      cmd_err    <= 1'b0;
      cmd_addr   <= '0;
      cmd_wdata  <= '0;
      last_grant <= 1'b1;
    end else if (take) begin
      cmd_id     <= win_id;
      cmd_we     <= win_we;
      cmd_err    <= (win_addr[2:0] != 3'b000);
      cmd_addr   <= win_addr;
      cmd_wdata  <= win_wdata;
      last_grant <= win_id;
    end
  end

  // ------------------------------------------------------------------------
  // Read data capture at the edge closing an aligned read ACCESS. Each port
  // keeps its own copy so one requester's data never disturbs the other's.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else if ((state == ACCESS) && !cmd_err && !cmd_we) begin
      if (cmd_id) r1_rdata <= mem_read_data;
      else        r0_rdata <= mem_read_data;
    end
  end

  // ------------------------------------------------------------------------
  // FSM: outputs. Strobes are decoded from the registered state only, so an
  // asynchronous reset drops them immediately.
  // ------------------------------------------------------------------------
  always_comb begin
    r0_gnt         = 1'b0;
    r1_gnt         = 1'b0;
    r0_rvalid      = 1'b0;
    r1_rvalid      = 1'b0;
    r0_err         = 1'b0;
    r1_err         = 1'b0;
    mem_MemRead    = 1'b0;
    mem_MemWrite   = 1'b0;
    mem_address    = cmd_addr;
    mem_write_data = cmd_wdata;
    busy           = (state != IDLE);
    dbg_state      = state;
    case (state)
      ACCESS: begin
        r0_gnt = ~cmd_id;
        r1_gnt = cmd_id;
        if (!cmd_err) begin
          mem_MemWrite = cmd_we;
          mem_MemRead  = ~cmd_we;
        end
      end
      RESP: begin
        if (cmd_err) begin
          r0_err = ~cmd_id;
          r1_err = cmd_id;
        end else if (!cmd_we) begin
          r0_rvalid = ~cmd_id;
          r1_rvalid = cmd_id;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Directed bench for data_mem_arbiter with a behavioural DataMemory
// (word array, combinational read, write on the rising edge). Inputs are
// driven 1 time unit after the rising edge, outputs sampled on the falling
// edge. Cycle numbering inside a scenario: the command is presented after
// edge P; "neg1" is the falling edge before the sampling edge, "neg2" is the
// ACCESS cycle (gnt + strobe), "neg3" the RESP cycle (rvalid / err).
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 64;

  localparam logic [63:0] V_FIRST = 64'h1122334455667788;
  localparam logic [63:0] V_AA    = 64'hAAAAAAAAAAAAAAAA;
  localparam logic [63:0] V_55    = 64'h5555555555555555;
  localparam logic [63:0] V_TOP   = 64'h0123456789ABCDEF;
  localparam logic [63:0] V_DEAD  = 64'hDEADBEEFCAFEF00D;
  localparam logic [63:0] V_ONES  = 64'hFFFFFFFFFFFFFFFF;

  logic              clk;
  logic              reset;
  logic              r0_req, r0_we, r0_gnt, r0_rvalid, r0_err;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata, r0_rdata;
  logic              r1_req, r1_we, r1_gnt, r1_rvalid, r1_err;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata, r1_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data, mem_read_data;
  logic              mem_MemRead, mem_MemWrite;
  logic              busy;
  logic [1:0]        dbg_state;

  int n_run;
  int n_fail;

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_read_data(mem_read_data),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DataMemory model ----------------
  logic [63:0] mem_words [128];
  initial begin
    for (int i = 0; i < 128; i++) mem_words[i] = '0;
  end
  always @(posedge clk) begin
    if (mem_MemWrite) mem_words[mem_address[9:3]] <= mem_write_data;
  end
  assign mem_read_data = mem_MemRead ? mem_words[mem_address[9:3]] : '0;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic id, input logic we, input logic [9:0] addr,
                         input logic [63:0] wd);
    if (id) begin
      r1_req = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wd;
    end else begin
      r0_req = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = wd;
    end
  endtask

  task automatic pulse_reset();
    step();
    reset = 1'b1;
    r0_req = 1'b0;
    r1_req = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    n_run++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
    n_run++; if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err, mem_MemRead, mem_MemWrite, busy} !== 9'b0) begin
      n_fail++; $display("FAIL rst_pulses: got %b exp 000000000",
        {r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err, mem_MemRead, mem_MemWrite, busy}); end
    n_run++; if ({r0_rdata, r1_rdata, mem_write_data} !== 192'b0 || mem_address !== 10'd0) begin
      n_fail++; $display("FAIL rst_data: got r0=%h r1=%h wd=%h a=%0d exp all 0", r0_rdata, r1_rdata, mem_write_data, mem_address); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single_rw();
    step(); set_cmd(1'b0, 1'b1, 10'd0, V_FIRST);
    @(negedge clk);
    n_run++; if (r0_gnt !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL w_neg1: got gnt=%b busy=%b exp 0 0", r0_gnt, busy); end
    @(negedge clk);
    n_run++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin n_fail++; $display("FAIL w_gnt: got r0=%b r1=%b exp 1 0", r0_gnt, r1_gnt); end
    n_run++; if (mem_MemWrite !== 1'b1 || mem_MemRead !== 1'b0) begin n_fail++; $display("FAIL w_strobe: got we=%b re=%b exp 1 0", mem_MemWrite, mem_MemRead); end
    n_run++; if (mem_address !== 10'd0 || mem_write_data !== V_FIRST) begin n_fail++; $display("FAIL w_bus: got a=%0d d=%h exp 0 %h", mem_address, mem_write_data, V_FIRST); end
    step(); r0_req = 1'b0;
    @(negedge clk);
    n_run++; if (r0_gnt !== 1'b0 || mem_MemWrite !== 1'b0) begin n_fail++; $display("FAIL w_one_cycle: got gnt=%b we=%b exp 0 0", r0_gnt, mem_MemWrite); end
    n_run++; if (r0_rvalid !== 1'b0 || r0_err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL w_resp: got rv=%b err=%b busy=%b exp 0 0 1", r0_rvalid, r0_err, busy); end

    step(); set_cmd(1'b0, 1'b0, 10'd0, 64'd0);
    @(negedge clk);
    @(negedge clk);
    n_run++; if (r0_gnt !== 1'b1 || mem_MemRead !== 1'b1 || mem_MemWrite !== 1'b0) begin
      n_fail++; $display("FAIL r_gnt: got gnt=%b re=%b we=%b exp 1 1 0", r0_gnt, mem_MemRead, mem_MemWrite); end
    step(); r0_req = 1'b0;
    @(negedge clk);
    n_run++; if (r0_rvalid !== 1'b1 || r0_rdata !== V_FIRST) begin n_fail++; $display("FAIL r_data: got rv=%b d=%h exp 1 %h", r0_rvalid, r0_rdata, V_FIRST); end
    n_run++; if (r1_rvalid !== 1'b0) begin n_fail++; $display("FAIL r_other_port: got r1_rvalid=%b exp 0", r1_rvalid); end
    @(negedge clk);
    n_run++; if (r0_rvalid !== 1'b0 || r0_rdata !== V_FIRST) begin n_fail++; $display("FAIL r_hold: got rv=%b d=%h exp 0 %h", r0_rvalid, r0_rdata, V_FIRST); end
  endtask

  task automatic test_tie();
    pulse_reset();
    step(); set_cmd(1'b0, 1'b1, 10'd8, V_AA); set_cmd(1'b1, 1'b1, 10'd16, V_55);
    @(negedge clk);
    @(negedge clk);
    n_run++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0 || mem_address !== 10'd8 || mem_write_data !== V_AA) begin
      n_fail++; $display("FAIL tie_first: got r0=%b r1=%b a=%0d d=%h exp 1 0 8 %h", r0_gnt, r1_gnt, mem_address, mem_write_data, V_AA); end
    step(); r0_req = 1'b0;
    @(negedge clk);
    n_run++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0 || mem_MemWrite !== 1'b0) begin
      n_fail++; $display("FAIL tie_gap: got r0=%b r1=%b we=%b exp 0 0 0", r0_gnt, r1_gnt, mem_MemWrite); end
    @(negedge clk);
    n_run++; if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0 || mem_address !== 10'd16 || mem_write_data !== V_55 || mem_MemWrite !== 1'b1) begin
      n_fail++; $display("FAIL tie_second: got r1=%b r0=%b a=%0d d=%h we=%b exp 1 0 16 %h 1", r1_gnt, r0_gnt, mem_address, mem_write_data, mem_MemWrite, V_55); end
    step(); r1_req = 1'b0;
    @(negedge clk);

    // Readback of both, issued together: last grant was r1 so r0 goes first.
    step(); set_cmd(1'b0, 1'b0, 10'd8, 64'd0); set_cmd(1'b1, 1'b0, 10'd16, 64'd0);
    @(negedge clk);
    @(negedge clk);
    step(); r0_req = 1'b0;
    @(negedge clk);
    n_run++; if (r0_rvalid !== 1'b1 || r0_rdata !== V_AA) begin n_fail++; $display("FAIL rb_8: got rv=%b d=%h exp 1 %h", r0_rvalid, r0_rdata, V_AA); end
    @(negedge clk);
    step(); r1_req = 1'b0;
    @(negedge clk);
    n_run++; if (r1_rvalid !== 1'b1 || r1_rdata !== V_55) begin n_fail++; $display("FAIL rb_16: got rv=%b d=%h exp 1 %h", r1_rvalid, r1_rdata, V_55); end
  endtask

  task automatic test_back_to_back();
    int phase;
    logic port;
    logic is_gnt;
    step(); set_cmd(1'b0, 1'b0, 10'd8, 64'd0); set_cmd(1'b1, 1'b0, 10'd16, 64'd0);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 17) begin
        phase  = k - 2;
        port   = ((phase / 2) % 2) == 1;
        is_gnt = (phase % 2) == 0;
        n_run++; if (r0_gnt !== (is_gnt && !port) || r1_gnt !== (is_gnt && port)) begin
          n_fail++; $display("FAIL b2b_gnt k=%0d: got r0=%b r1=%b exp %b %b", k, r0_gnt, r1_gnt, is_gnt && !port, is_gnt && port); end
        n_run++; if (r0_rvalid !== (!is_gnt && !port) || r1_rvalid !== (!is_gnt && port)) begin
          n_fail++; $display("FAIL b2b_rvalid k=%0d: got r0=%b r1=%b exp %b %b", k, r0_rvalid, r1_rvalid, !is_gnt && !port, !is_gnt && port); end
        n_run++; if (busy !== 1'b1 || mem_MemRead !== is_gnt || mem_MemWrite !== 1'b0) begin
          n_fail++; $display("FAIL b2b_busy k=%0d: got busy=%b re=%b we=%b exp 1 %b 0", k, busy, mem_MemRead, mem_MemWrite, is_gnt); end
        if (!is_gnt && !port) begin
          n_run++; if (r0_rdata !== V_AA) begin n_fail++; $display("FAIL b2b_r0_data k=%0d: got %h exp %h", k, r0_rdata, V_AA); end
        end
        if (!is_gnt && port) begin
          n_run++; if (r1_rdata !== V_55) begin n_fail++; $display("FAIL b2b_r1_data k=%0d: got %h exp %h", k, r1_rdata, V_55); end
        end
        // Each port takes four grants, then drops req after its last gnt.
        if (k == 14) begin step(); r0_req = 1'b0; end
        if (k == 16) begin step(); r1_req = 1'b0; end
      end else if (k == 18) begin
        n_run++; if (busy !== 1'b0 || r0_gnt !== 1'b0 || r1_gnt !== 1'b0) begin
          n_fail++; $display("FAIL b2b_idle: got busy=%b r0=%b r1=%b exp 0 0 0", busy, r0_gnt, r1_gnt); end
      end
    end
  endtask

  task automatic test_misaligned();
    step(); set_cmd(1'b1, 1'b0, 10'h003, 64'd0);
    @(negedge clk);
    @(negedge clk);
    n_run++; if (r1_gnt !== 1'b1 || mem_MemRead !== 1'b0 || mem_MemWrite !== 1'b0) begin
      n_fail++; $display("FAIL mis_r_gnt: got gnt=%b re=%b we=%b exp 1 0 0", r1_gnt, mem_MemRead, mem_MemWrite); end
    step(); r1_req = 1'b0;
    @(negedge clk);
    n_run++; if (r1_err !== 1'b1 || r1_rvalid !== 1'b0 || r0_err !== 1'b0) begin
      n_fail++; $display("FAIL mis_r_err: got r1_err=%b rv=%b r0_err=%b exp 1 0 0", r1_err, r1_rvalid, r0_err); end
    @(negedge clk);
    n_run++; if (r1_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mis_r_once: got err=%b busy=%b exp 0 0", r1_err, busy); end

    step(); set_cmd(1'b0, 1'b1, 10'h00D, V_ONES);
    @(negedge clk);
    @(negedge clk);
    n_run++; if (r0_gnt !== 1'b1 || mem_MemRead !== 1'b0 || mem_MemWrite !== 1'b0) begin
      n_fail++; $display("FAIL mis_w_gnt: got gnt=%b re=%b we=%b exp 1 0 0", r0_gnt, mem_MemRead, mem_MemWrite); end
    step(); r0_req = 1'b0;
    @(negedge clk);
    n_run++; if (r0_err !== 1'b1 || r0_rvalid !== 1'b0 || r1_err !== 1'b0) begin
      n_fail++; $display("FAIL mis_w_err: got r0_err=%b rv=%b r1_err=%b exp 1 0 0", r0_err, r0_rvalid, r1_err); end
    @(negedge clk);
    n_run++; if (r0_err !== 1'b0) begin n_fail++; $display("FAIL mis_w_once: got err=%b exp 0", r0_err); end
  endtask

  task automatic test_boundary();
    step(); set_cmd(1'b1, 1'b1, 10'd1016, V_TOP);
    @(negedge clk);
    @(negedge clk);
    n_run++; if (mem_address !== 10'd1016 || mem_MemWrite !== 1'b1) begin
      n_fail++; $display("FAIL top_w: got a=%0d we=%b exp 1016 1", mem_address, mem_MemWrite); end
    step(); r1_req = 1'b0;
    @(negedge clk);
    step(); set_cmd(1'b1, 1'b0, 10'd1016, 64'd0);
    @(negedge clk);
    @(negedge clk);
    step(); r1_req = 1'b0;
    @(negedge clk);
    n_run++; if (r1_rvalid !== 1'b1 || r1_rdata !== V_TOP) begin n_fail++; $display("FAIL top_r: got rv=%b d=%h exp 1 %h", r1_rvalid, r1_rdata, V_TOP); end
    // The misaligned write to 0x00D must not have touched word 8..15.
    step(); set_cmd(1'b0, 1'b0, 10'd8, 64'd0);
    @(negedge clk);
    @(negedge clk);
    step(); r0_req = 1'b0;
    @(negedge clk);
    n_run++; if (r0_rvalid !== 1'b1 || r0_rdata !== V_AA) begin n_fail++; $display("FAIL mis_no_commit: got rv=%b d=%h exp 1 %h", r0_rvalid, r0_rdata, V_AA); end
  endtask

  task automatic test_reset_mid_access();
    step(); set_cmd(1'b0, 1'b1, 10'd24, V_DEAD);
    @(negedge clk);
    @(negedge clk);
    n_run++; if (mem_MemWrite !== 1'b1 || mem_address !== 10'd24) begin
      n_fail++; $display("FAIL mid_pre: got we=%b a=%0d exp 1 24", mem_MemWrite, mem_address); end
    #2 reset = 1'b1;
    #1;
    n_run++; if (mem_MemWrite !== 1'b0 || r0_gnt !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL mid_drop: got we=%b gnt=%b busy=%b st=%0d exp 0 0 0 0", mem_MemWrite, r0_gnt, busy, dbg_state); end
    n_run++; if (mem_address !== 10'd0 || mem_write_data !== 64'd0 || r0_rdata !== 64'd0 || r1_rdata !== 64'd0) begin
      n_fail++; $display("FAIL mid_clear: got a=%0d wd=%h r0=%h r1=%h exp all 0", mem_address, mem_write_data, r0_rdata, r1_rdata); end
    r0_req = 1'b0;
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    n_run++; if (r0_rvalid !== 1'b0 || r0_err !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_no_resp: got rv=%b err=%b busy=%b exp 0 0 0", r0_rvalid, r0_err, busy); end

    // Load known data into r0_rdata first so the @24 read must change it.
    step(); set_cmd(1'b0, 1'b0, 10'd8, 64'd0);
    @(negedge clk);
    @(negedge clk);
    step(); r0_req = 1'b0;
    @(negedge clk);
    n_run++; if (r0_rdata !== V_AA) begin n_fail++; $display("FAIL mid_pre_read: got %h exp %h", r0_rdata, V_AA); end
    step(); set_cmd(1'b0, 1'b0, 10'd24, 64'd0);
    @(negedge clk);
    @(negedge clk);
    step(); r0_req = 1'b0;
    @(negedge clk);
    n_run++; if (r0_rvalid !== 1'b1 || r0_rdata !== 64'd0) begin n_fail++; $display("FAIL mid_no_commit: got rv=%b d=%h exp 1 0", r0_rvalid, r0_rdata); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_run    = 0;
    n_fail   = 0;
    reset    = 1'b1;
    r0_req   = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req   = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
    test_reset();
    test_single_rw();
    test_tie();
    test_back_to_back();
    test_misaligned();
    test_boundary();
    test_reset_mid_access();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Two-requester arbiter and sequencer in front of the 64-bit, byte-addressed, big-endian DataMemory (10-bit address). Requester 0 is the core load/store path; requester 1 is the DMA/debug port. The block arbitrates round-robin, registers one command, drives DataMemory for exactly one cycle and returns read data with a valid pulse. It also rejects misaligned addresses with an error pulse.

Parameters:
ADDR_W, 10, byte address width (matches DataMemory)
DATA_W, 64, data width (8-byte words)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
r0_req  in  1  requester 0 request; held with command until r0_gnt
r0_we  in  1  1 = write, 0 = read
r0_addr  in  ADDR_W  byte address
r0_wdata  in  DATA_W  write data
r0_gnt  out  1  one-cycle grant/accept pulse
r0_rvalid  out  1  one-cycle read-data-valid pulse
r0_rdata  out  DATA_W  read data, valid with r0_rvalid, held until next read
r0_err  out  1  one-cycle misaligned-access pulse
r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata, r1_err  same as r0_*, for requester 1
mem_address  out  ADDR_W  to DataMemory address
mem_write_data  out  DATA_W  to DataMemory write_data
mem_MemRead  out  1  to DataMemory MemRead
mem_MemWrite  out  1  to DataMemory MemWrite
mem_read_data  in  DATA_W  from DataMemory read_data; combinational w.r.t. address/MemRead
busy  out  1  high in ACCESS and RESP

Behaviour:
- Reset (async, immediate): state IDLE. All gnt/rvalid/err/mem_MemRead/mem_MemWrite/busy = 0. rdata, mem_address, mem_write_data = 0. last_grant = 1, so r0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP. Arbitration happens on the clock edge leaving IDLE or RESP.
- Arbitration:
  - Only one req high: that requester wins.
  - Both high: the requester not equal to last_grant wins.
  - Winner's we/addr/wdata/id are latched and last_grant <= winner id.
  - No req: IDLE (from RESP: to IDLE).
- ACCESS (one cycle):
  - winner's gnt = 1.
  - mem_address/mem_write_data are driven from the latched command.
  - If latched addr[2:0] == 0: mem_MemWrite = we, mem_MemRead = ~we.
    - A write commits at the closing edge.
    - For a read, mem_read_data is captured into the winner's rdata at the closing edge.
  - If addr[2:0] != 0: both mem strobes stay 0 and an error flag is latched.
  - Next state: RESP.
- RESP (one cycle):
  - Aligned read: winner rvalid = 1.
  - Misaligned (read or write): winner err = 1.
  - Aligned write: no pulse; gnt is the completion.
  - Arbitrate again: req pending -> ACCESS, else IDLE.
- Latency/throughput:
  - req sampled at edge E -> gnt and mem strobe during cycle E+1 -> rvalid/err during cycle E+2.
  - Back-to-back: one access every 2 cycles.
- Requester rule: req and fields are stable from assertion until the cycle gnt is high. The requester may drop req or present a new command after that cycle. The arbiter never samples req during ACCESS.
- mem strobes are high only in ACCESS and never both high together. The non-granted requester's data never reaches mem_write_data while a strobe is high.
- Round-robin guarantees a continuously requesting port waits at most one foreign access.
- Reset mid-ACCESS: strobes drop immediately; the pending write does not commit if reset asserts before the edge. No rvalid/err is issued for the aborted command.
- Full 10-bit range is valid; the highest aligned address is 1016. There is no wrap-around.

Test Plan:
- Reset; r0 write 0x1122334455667788 @0 -> r0_gnt and mem_MemWrite high exactly 1 cycle, mem_address = 0. Then r0 read @0 -> r0_rvalid 2 cycles after req sample, r0_rdata = 0x1122334455667788.
- r0 write 0xAAAA…AA @8 and r1 write 0x5555…55 @16 in the same cycle after reset -> r0 granted first, r1 granted 2 cycles later. Readback: @8 = 0xAAAA…AA, @16 = 0x5555…55.
- r0 and r1 reads held continuously for 8 grants -> grants alternate r0,r1,r0,… 2 cycles apart, busy stays 1, each rvalid goes to the matching port.
- r1 read @0x003, then r0 write @0x00D -> r1_err then r0_err pulse once each, mem strobes never high, no rvalid.
- r0 write 0xDEADBEEFCAFEF00D @24; assert reset mid-ACCESS before the edge -> mem_MemWrite falls immediately, all outputs return to reset values. Read @24 afterwards returns the memory's reset value 0.
